// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM states,
// default operand width and the iteration-counter width helper.
package seq_divider_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter must hold WIDTH itself, not just WIDTH-1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// start/busy/done handshake and operand/result bus of the sequential divider.
interface seq_divider_if #(
  parameter int WIDTH = seq_divider_pkg::DEF_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider_add_sub.sv
// Combinational ripple-carry adder/subtractor; sub=1 gives in_1-in_2 with
// Cout=1 meaning no borrow.
module add_sub_unit #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic             sub,
  output logic [WIDTH-1:0] s_mod,
  output logic             Cout
);
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] b_eff;

  always_comb begin
    b_eff    = in_2 ^ {WIDTH{sub}};
    carry    = '0;
    carry[0] = sub;
    s_mod    = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      s_mod[i]   = in_1[i] ^ b_eff[i] ^ carry[i];
      carry[i+1] = (in_1[i] & b_eff[i]) | (carry[i] & (in_1[i] ^ b_eff[i]));
    end
    Cout = carry[WIDTH];
  end
endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock via trial
// subtraction, with start/busy/done handshake and divide-by-zero flag.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic          clk,
  input logic          rst,
  seq_divider_if.slave bus
);
  localparam int CNT_W = cnt_width(WIDTH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH:0]     r_q, r_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               dbz_q, dbz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     rs;
  logic [WIDTH:0]     trial;
  logic               cout;
  logic               r_msb_unused;

  // Shifted R is always < 2*divisor, so R's top bit never feeds the next shift.
  assign rs           = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign r_msb_unused = r_q[WIDTH];

  add_sub_unit #(.WIDTH(WIDTH + 1)) u_add_sub (
    .in_1  (rs),
    .in_2  ({1'b0, dvsr_q}),
    .sub   (1'b1),
    .s_mod (trial),
    .Cout  (cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dvsr_d  = dvsr_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          dvsr_d = bus.divisor;
          if (bus.divisor != '0) begin
            q_d     = bus.dividend;
            r_d     = '0;
            cnt_d   = '0;
            dbz_d   = 1'b0;
            state_d = ST_DIV;
          end else begin
            quot_d  = '1;
            rem_d   = bus.dividend;
            dbz_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DIV: begin
        if (cout) begin
          r_d = trial;
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = rs;
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          quot_d  = q_d;
          rem_d   = r_d[WIDTH-1:0];
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_DIV);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dvsr_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dvsr_q  <= dvsr_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
endmodule
